// File: rtl/mult_sweep_monitor.sv
// Exhaustive sweep harness for a combinational W x W approximate multiplier.
// Streams every operand pair to the multiplier and accumulates error-distance statistics.
module mult_sweep_monitor #(
  parameter  int unsigned W  = 6,
  localparam int unsigned PW = 2*W + 1,
  localparam int unsigned SW = 2*W + PW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [W-1:0]    op_a,
  output logic [W-1:0]    op_b,
  input  logic [PW-1:0]   prod,
  output logic            busy,
  output logic            done,
  output logic [2*W:0]    err_cnt,
  output logic [SW-1:0]   sum_ed,
  output logic [PW-1:0]   max_ed,
  output logic [W-1:0]    worst_a,
  output logic [W-1:0]    worst_b
);

  localparam int unsigned CW = 2*W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic           last_c, clear_c;
  logic [PW-1:0]  exact_c, ed_c;

  // stage-1 capture of the pair presented this cycle
  logic           v1, neq1;
  logic [PW-1:0]  ed1;
  logic [W-1:0]   a1, b1;

  assign last_c  = (op_a == '1) && (op_b == '1);
  assign clear_c = start && ((state == S_IDLE) || (state == S_DONE));
  assign exact_c = PW'(op_a) * PW'(op_b);
  assign ed_c    = (exact_c >= prod) ? (exact_c - prod) : (prod - exact_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)  state_nxt = S_SWEEP;
      S_SWEEP: if (last_c) state_nxt = S_DRAIN;
      S_DRAIN:             state_nxt = S_DONE;
      S_DONE:  if (start)  state_nxt = S_SWEEP;
      default:             state_nxt = S_IDLE;
    endcase
  end

  // status flags track the state being entered so they change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_SWEEP) || (state_nxt == S_DRAIN);
      done <= (state_nxt == S_DONE);
    end
  end

  // operand counter: op_b inner loop, holds at the final pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (clear_c) begin
      op_a <= '0;
      op_b <= '0;
    end else if ((state == S_SWEEP) && !last_c) begin
      op_b <= op_b + W'(1);
      if (op_b == '1) op_a <= op_a + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      neq1 <= 1'b0;
      ed1  <= '0;
      a1   <= '0;
      b1   <= '0;
    end else begin
      v1   <= (state == S_SWEEP);
      neq1 <= (ed_c != '0);
      ed1  <= ed_c;
      a1   <= op_a;
      b1   <= op_b;
    end
  end

  // accumulate; strict compare keeps the earliest worst pair on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else if (clear_c) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else if (v1) begin
      err_cnt <= err_cnt + CW'(neq1);
      sum_ed  <= sum_ed + SW'(ed1);
      if (ed1 > max_ed) begin
        max_ed  <= ed1;
        worst_a <= a1;
        worst_b <= b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_sweep_monitor.sv
// Scoreboard bench for mult_sweep_monitor with a behavioural multiplier stub.
// Expected statistics are queued per sweep and checked when done rises.
module tb_mult_sweep_monitor;

  localparam int unsigned W  = 6;
  localparam int unsigned PW = 2*W + 1;
  localparam int unsigned SW = 2*W + PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic [PW-1:0] prod;
  logic          busy, done;
  logic [2*W:0]  err_cnt;
  logic [SW-1:0] sum_ed;
  logic [PW-1:0] max_ed;
  logic [W-1:0]  worst_a, worst_b;

  typedef struct {
    int ec;
    int sum;
    int mx;
    int wa;
    int wb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;

  mult_sweep_monitor #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .prod(prod),
    .busy(busy), .done(done),
    .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed),
    .worst_a(worst_a), .worst_b(worst_b)
  );

  always #5 clk = ~clk;

  // multiplier stub: 0 exact, 1 over by one, 2 zero at (51,56), 3 all-ones at (0,0)
  always_comb begin
    int p;
    p = int'(op_a) * int'(op_b);
    case (mode)
      1:       p = p + 1;
      2:       if (op_a == 6'd51 && op_b == 6'd56) p = 0;
      3:       if (op_a == 6'd0 && op_b == 6'd0) p = 8191;
      default: p = p;
    endcase
    prod = PW'(p);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int m, input exp_t e, input int extra);
    int k;
    bit seq_ok;
    mode = m;
    sb.push_back(e);
    seq_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (k = 1; k <= 5000; k++) begin
      @(negedge clk);
      start = (k == extra);
      if (k == 1) begin
        chk("clear_done", done, 0);
        chk("clear_err_cnt", err_cnt, 0);
        chk("clear_max_ed", max_ed, 0);
      end
      if (done) break;
      if (k <= 4096 && (op_a != W'((k-1) >> 6) || op_b != W'((k-1) & 63) || !busy)) seq_ok = 1'b0;
      if (k == 4097 && (!busy || op_a != 6'd63 || op_b != 6'd63)) seq_ok = 1'b0;
    end
    start = 1'b0;
    chk("done_cycle", k, 4098);
    chk("busy_at_done", busy, 0);
    chk("sweep_order", seq_ok, 1);
  endtask

  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("err_cnt", err_cnt, e.ec);
          chk("sum_ed", sum_ed, e.sum);
          chk("max_ed", max_ed, e.mx);
          chk("worst_a", worst_a, e.wa);
          chk("worst_b", worst_b, e.wb);
        end
      end
      done_q = done;
    end
  end

  initial begin : stim
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, exp_t'{0, 0, 0, 0, 0}, 0);
    run_sweep(1, exp_t'{4096, 4096, 1, 0, 0}, 100);
    run_sweep(2, exp_t'{1, 2856, 2856, 51, 56}, 0);
    run_sweep(3, exp_t'{1, 8191, 8191, 0, 0}, 0);

    // abort mid-sweep with non-zero statistics
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 3000 && op_a != 6'd20; k++) @(negedge clk);
    chk("reached_a20", op_a, 20);
    chk("pre_abort_err_nonzero", err_cnt != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_op_a", op_a, 0);
    chk("abort_op_b", op_b, 0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("abort_sum_ed", sum_ed, 0);
    chk("abort_max_ed", max_ed, 0);
    chk("abort_worst", {worst_a, worst_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_abort", busy, 0);

    run_sweep(1, exp_t'{4096, 4096, 1, 0, 0}, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
